// File: rtl/fb_scanout_if.sv
// rtl/fb_scanout_if.sv - framebuffer read, buffer swap and video output bundle
interface fb_scanout_if #(
  parameter int FB_WIDTH  = 400,
  parameter int FB_HEIGHT = 240
);
  localparam int XW = $clog2(FB_WIDTH) + 1;
  localparam int YW = $clog2(FB_HEIGHT) + 1;

  logic [XW-1:0] fb_rd_x;
  logic [YW-1:0] fb_rd_y;
  logic          fb_rd_buffer;
  logic          fb_rd_en;
  logic [15:0]   fb_rd_data;
  logic          ctrl_swap;
  logic          swap_pending;
  logic          front_buffer;
  logic          swap_done;
  logic [4:0]    vid_r;
  logic [4:0]    vid_g;
  logic [4:0]    vid_b;
  logic          vid_hsync;
  logic          vid_vsync;
  logic          vid_de;

  modport master (
    output fb_rd_x, fb_rd_y, fb_rd_buffer, fb_rd_en,
    input  fb_rd_data, ctrl_swap,
    output swap_pending, front_buffer, swap_done,
    output vid_r, vid_g, vid_b, vid_hsync, vid_vsync, vid_de
  );

  modport slave (
    input  fb_rd_x, fb_rd_y, fb_rd_buffer, fb_rd_en,
    output fb_rd_data, ctrl_swap,
    input  swap_pending, front_buffer, swap_done,
    input  vid_r, vid_g, vid_b, vid_hsync, vid_vsync, vid_de
  );
endinterface

// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - 2x upscaling framebuffer scanout with frame-synchronous double-buffer swap
module fb_scanout #(
  parameter int FB_WIDTH  = 400,
  parameter int FB_HEIGHT = 240,
  parameter int H_ACTIVE  = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 48,
  parameter int H_BACK    = 40,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 13,
  parameter int V_SYNC    = 3,
  parameter int V_BACK    = 29
) (
  input  logic        clk,
  input  logic        reset_n,
  fb_scanout_if.master bus
);
  localparam int XW      = $clog2(FB_WIDTH) + 1;
  localparam int YW      = $clog2(FB_HEIGHT) + 1;
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  typedef enum logic {S_IDLE, S_PENDING} swap_state_t;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          active;
  logic          frame_end;
  logic          vid_de;
  logic          vid_hsync;
  logic          vid_vsync;
  logic          swap_prev;
  logic          swap_edge;
  logic          front_buffer;
  logic          swap_done;
  logic          toggle;
  swap_state_t   state;
  swap_state_t   state_nxt;

  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign swap_edge = bus.ctrl_swap && !swap_prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Timing flags lag the address by one cycle so they line up with fb_rd_data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vid_de    <= 1'b0;
      vid_hsync <= 1'b1;
      vid_vsync <= 1'b1;
    end else begin
      vid_de    <= active;
      vid_hsync <= !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
      vid_vsync <= !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      swap_prev    <= 1'b0;
      front_buffer <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      state        <= state_nxt;
      swap_prev    <= bus.ctrl_swap;
      front_buffer <= front_buffer ^ toggle;
      swap_done    <= toggle;
    end
  end

  // A request landing on the boundary cycle itself is applied immediately.
  always_comb begin
    state_nxt = state;
    toggle    = 1'b0;
    case (state)
      S_IDLE: begin
        if (swap_edge) begin
          if (frame_end) toggle = 1'b1;
          else state_nxt = S_PENDING;
        end
      end
      S_PENDING: begin
        if (frame_end) begin
          toggle    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.fb_rd_en     = active;
  assign bus.fb_rd_x      = active ? XW'(h_cnt >> 1) : '0;
  assign bus.fb_rd_y      = active ? YW'(v_cnt >> 1) : '0;
  assign bus.fb_rd_buffer = front_buffer;
  assign bus.front_buffer = front_buffer;
  assign bus.swap_pending = (state == S_PENDING);
  assign bus.swap_done    = swap_done;
  assign bus.vid_de       = vid_de;
  assign bus.vid_hsync    = vid_hsync;
  assign bus.vid_vsync    = vid_vsync;
  assign bus.vid_r        = vid_de ? bus.fb_rd_data[15:11] : '0;
  assign bus.vid_g        = vid_de ? bus.fb_rd_data[10:6]  : '0;
  assign bus.vid_b        = vid_de ? bus.fb_rd_data[5:1]   : '0;
endmodule
